// File: rtl/interconn_pkg.sv
// Shared constants and helpers for the round-robin buffered crossbar.
package interconn_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = 128;
  localparam int D_DEF = 4;

  // Port-index width; a single port still needs one bit to carry an index.
  function automatic int clog2c(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/interconn_rr_if.sv
// Sender/receiver bundle of the crossbar; master is the MVU side, slave the crossbar.
interface interconn_rr_if #(
  parameter int N = interconn_pkg::N_DEF,
  parameter int W = interconn_pkg::W_DEF
);
  localparam int A = interconn_pkg::clog2c(N);

  logic [N-1:0]   send_en;
  logic [N*A-1:0] send_to;
  logic [N*W-1:0] send_word;
  logic [N-1:0]   send_rdy;
  logic [N-1:0]   recv_en;
  logic [N*W-1:0] recv_word;
  logic [N*A-1:0] recv_from;
  logic [N-1:0]   recv_rdy;

  modport master (
    output send_en, send_to, send_word, recv_rdy,
    input  send_rdy, recv_en, recv_word, recv_from
  );

  modport slave (
    input  send_en, send_to, send_word, recv_rdy,
    output send_rdy, recv_en, recv_word, recv_from
  );

endinterface

// File: rtl/interconn_fifo.sv
// Synchronous per-destination FIFO; storage is cleared on reset so the head reads zero.
module interconn_fifo #(
  parameter int WIDTH = 131,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [CW-1:0]    cnt_q;
  logic             pop_s;
  logic             push_s;

  // A pop of an empty FIFO is dropped; a push into a full one needs a concurrent pop.
  assign pop_s  = pop_i && (cnt_q != CW'(0));
  assign push_s = push_i && ((cnt_q != CW'(DEPTH)) || pop_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      rd_q  <= AW'(0);
      wr_q  <= AW'(0);
      cnt_q <= CW'(0);
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_s) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == CW'(0));
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/interconn_rr.sv
// Buffered N x N crossbar: senders address a destination per word, one
// round-robin arbiter and FIFO per destination.
module interconn_rr
  import interconn_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  parameter int D = D_DEF
) (
  input logic           clk,
  input logic           clr_n,
  interconn_rr_if.slave bus
);
  localparam int A  = clog2c(N);
  localparam int FW = A + W;

  logic [N-1:0] gnt_all_s [N];
  logic [N-1:0] send_rdy_s;

  for (genvar j = 0; j < N; j++) begin : g_dst
    logic [N-1:0]  req_s;
    logic [N-1:0]  gnt_s;
    logic [A-1:0]  ptr_q;
    logic [A-1:0]  ptr_d;
    logic [A-1:0]  gidx_s;
    logic          found_s;
    logic          can_s;
    logic          full_s;
    logic          empty_s;
    logic [FW-1:0] push_data_s;
    logic [FW-1:0] head_s;

    // Requesters aiming at this destination; a single port has nowhere else to go.
    always_comb begin
      req_s = '0;
      for (int i = 0; i < N; i++) begin
        if (N == 1) begin
          req_s[i] = bus.send_en[i];
        end else begin
          req_s[i] = bus.send_en[i] && (bus.send_to[i*A +: A] == A'(j));
        end
      end
    end

    // A full FIFO may still accept when its head leaves in the same cycle.
    assign can_s = clr_n && (!full_s || (bus.recv_rdy[j] && !empty_s));

    // First requester at or after ptr_q, wrapping modulo N.
    always_comb begin
      int idx;
      idx     = 0;
      gnt_s   = '0;
      gidx_s  = A'(0);
      found_s = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr_q) + k) % N;
        if (!found_s && can_s && req_s[idx]) begin
          gnt_s[idx] = 1'b1;
          gidx_s     = A'(idx);
          found_s    = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end

    assign ptr_d = (int'(gidx_s) == N - 1) ? A'(0) : gidx_s + A'(1);

    // Round-robin pointer advances only past an actual grantee.
    always_ff @(posedge clk) begin
      if (!clr_n) begin
        ptr_q <= A'(0);
      end else if (found_s) begin
        ptr_q <= ptr_d;
      end else begin
        ptr_q <= ptr_q;
      end
    end

    assign push_data_s = {gidx_s, bus.send_word[int'(gidx_s)*W +: W]};
    assign gnt_all_s[j] = gnt_s;

    interconn_fifo #(
      .WIDTH (FW),
      .DEPTH (D)
    ) u_fifo (
      .clk     (clk),
      .clr_n   (clr_n),
      .push_i  (found_s),
      .pop_i   (bus.recv_rdy[j]),
      .wdata_i (push_data_s),
      .full_o  (full_s),
      .empty_o (empty_s),
      .head_o  (head_s)
    );

    assign bus.recv_en[j]           = !empty_s;
    assign bus.recv_from[j*A +: A]  = head_s[FW-1 -: A];
    assign bus.recv_word[j*W +: W]  = head_s[W-1:0];
  end

  // A sender targets one destination, so OR-ing the per-destination grants is safe.
  always_comb begin
    send_rdy_s = '0;
    for (int j = 0; j < N; j++) begin
      send_rdy_s = send_rdy_s | gnt_all_s[j];
    end
  end

  assign bus.send_rdy = send_rdy_s;

endmodule

// File: tb/tb_interconn_rr.sv
// Directed bench for interconn_rr: queue-based reference model on the N=8 instance
// plus literal spot checks, and small N=1 / N=6 instances for edge configurations.
module tb_interconn_rr;
  logic clk;
  logic clr_n;
  int   n_chk;
  int   n_err;

  interconn_rr_if #(.N(8), .W(128)) ifm ();
  interconn_rr_if #(.N(1), .W(16))  if1 ();
  interconn_rr_if #(.N(6), .W(16))  if6 ();

  interconn_rr #(.N(8), .W(128), .D(4)) dut_m (.clk(clk), .clr_n(clr_n), .bus(ifm));
  interconn_rr #(.N(1), .W(16),  .D(4)) dut_1 (.clk(clk), .clr_n(clr_n), .bus(if1));
  interconn_rr #(.N(6), .W(16),  .D(4)) dut_6 (.clk(clk), .clr_n(clr_n), .bus(if6));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic msend(input int i, input int dst, input logic [127:0] w, input logic en);
    ifm.send_en[i]              = en;
    ifm.send_to[i*3 +: 3]       = 3'(dst);
    ifm.send_word[i*128 +: 128] = w;
  endtask

  // Reference model: each destination is an ordered list plus a rotating start index.
  logic [127:0] mw [8][4];
  logic [2:0]   ms [8][4];
  int           mcnt [8];
  int           mptr [8];
  bit           model_on = 1'b0;

  always @(negedge clk) begin
    int g [8];
    int i;
    logic [7:0] esr;
    esr = 8'h00;
    for (int j = 0; j < 8; j++) begin
      g[j] = -1;
      if (clr_n && (mcnt[j] < 4 || ifm.recv_rdy[j])) begin
        for (int k = 0; k < 8; k++) begin
          i = (mptr[j] + k) % 8;
          if (g[j] < 0 && ifm.send_en[i] && int'(ifm.send_to[i*3 +: 3]) == j) g[j] = i;
        end
      end
      if (g[j] >= 0) esr[g[j]] = 1'b1;
    end
    if (model_on) begin
      chk("model send_rdy", 160'(ifm.send_rdy), 160'(esr));
      for (int j = 0; j < 8; j++) begin
        chk($sformatf("model recv_en[%0d]", j), 160'(ifm.recv_en[j]), 160'(mcnt[j] > 0));
        if (mcnt[j] > 0) begin
          chk($sformatf("model recv_word[%0d]", j), 160'(ifm.recv_word[j*128 +: 128]), 160'(mw[j][0]));
          chk($sformatf("model recv_from[%0d]", j), 160'(ifm.recv_from[j*3 +: 3]), 160'(ms[j][0]));
        end
      end
    end
    if (!clr_n) begin
      model_on = 1'b1;
      for (int j = 0; j < 8; j++) begin
        mcnt[j] = 0;
        mptr[j] = 0;
      end
    end else begin
      for (int j = 0; j < 8; j++) begin
        if (ifm.recv_rdy[j] && mcnt[j] > 0) begin
          for (int s = 0; s < 3; s++) begin
            mw[j][s] = mw[j][s+1];
            ms[j][s] = ms[j][s+1];
          end
          mcnt[j]--;
        end
        if (g[j] >= 0) begin
          mw[j][mcnt[j]] = ifm.send_word[g[j]*128 +: 128];
          ms[j][mcnt[j]] = 3'(g[j]);
          mcnt[j]++;
          mptr[j] = (g[j] + 1) % 8;
        end
      end
    end
  end

  initial begin
    int snd [3];
    logic [7:0] pat [3];
    int   wc;
    int   pc;
    logic acc;
    snd = '{0, 2, 5};
    pat = '{8'h01, 8'h04, 8'h20};
    n_chk = 0;
    n_err = 0;
    clk = 1'b0;
    clr_n = 1'b0;
    ifm.send_en = '0; ifm.send_to = '0; ifm.send_word = '0; ifm.recv_rdy = '0;
    if1.send_en = '0; if1.send_to = '0; if1.send_word = '0; if1.recv_rdy = '0;
    if6.send_en = '0; if6.send_to = '0; if6.send_word = '0; if6.recv_rdy = '0;

    // Reset with random traffic on the inputs.
    for (int c = 0; c < 3; c++) begin
      tick();
      ifm.send_en = 8'($urandom); ifm.send_to = 24'($urandom); ifm.recv_rdy = 8'($urandom);
      if6.send_en = 6'($urandom); if6.recv_rdy = 6'($urandom);
      if1.send_en = 1'($urandom); if1.recv_rdy = 1'($urandom);
      #1;
      chk("rst send_rdy", 160'(ifm.send_rdy), 160'd0);
      chk("rst recv_en", 160'(ifm.recv_en), 160'd0);
      chk("rst recv_word", 160'(ifm.recv_word != '0), 160'd0);
      chk("rst n6 send_rdy", 160'(if6.send_rdy), 160'd0);
      chk("rst n1 send_rdy", 160'(if1.send_rdy), 160'd0);
    end
    tick();
    clr_n = 1'b1;
    ifm.send_en = '0; ifm.send_to = '0; ifm.recv_rdy = '0;
    if6.send_en = '0; if6.recv_rdy = '0; if1.send_en = '0; if1.recv_rdy = '0;
    #1;
    chk("post-rst send_rdy", 160'(ifm.send_rdy), 160'd0);
    chk("post-rst recv_en", 160'(ifm.recv_en), 160'd0);
    chk("post-rst recv_word", 160'(ifm.recv_word != '0), 160'd0);
    chk("post-rst recv_from", 160'(ifm.recv_from), 160'd0);
    chk("post-rst n6 recv_en", 160'(if6.recv_en), 160'd0);
    chk("post-rst n1 recv_en", 160'(if1.recv_en), 160'd0);

    // Point to point: 3 -> 6.
    tick();
    msend(3, 6, 128'hA5, 1'b1);
    ifm.recv_rdy = 8'h40;
    #1;
    chk("p2p send_rdy", 160'(ifm.send_rdy), 160'h08);
    chk("p2p recv_en early", 160'(ifm.recv_en), 160'd0);
    tick();
    msend(3, 6, 128'hA5, 1'b0);
    #1;
    chk("p2p recv_en", 160'(ifm.recv_en), 160'h40);
    chk("p2p recv_word", 160'(ifm.recv_word[6*128 +: 128]), 160'hA5);
    chk("p2p recv_from", 160'(ifm.recv_from[18 +: 3]), 160'd3);
    tick();
    ifm.recv_rdy = 8'h00;
    #1;
    chk("p2p drained", 160'(ifm.recv_en), 160'd0);

    // Contention: 0, 2, 5 -> 1 with continuous pops.
    tick();
    ifm.recv_rdy = 8'h02;
    msend(0, 1, 128'h100, 1'b1);
    msend(2, 1, 128'h102, 1'b1);
    msend(5, 1, 128'h105, 1'b1);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr grant c%0d", c), 160'(ifm.send_rdy), 160'(pat[c % 3]));
      if (c > 0) begin
        chk($sformatf("rr recv_en c%0d", c), 160'(ifm.recv_en[1]), 160'd1);
        chk($sformatf("rr recv_from c%0d", c), 160'(ifm.recv_from[3 +: 3]), 160'(snd[(c - 1) % 3]));
      end
      tick();
    end
    ifm.send_en = '0;
    tick();
    tick();
    ifm.recv_rdy = 8'h00;

    // Back-pressure: 0 -> 7 with the receiver stalled, then released.
    wc = 0;
    for (int c = 0; c < 6; c++) begin
      msend(0, 7, 128'(wc), 1'b1);
      #1;
      acc = ifm.send_rdy[0];
      chk($sformatf("bp accept c%0d", c), 160'(acc), 160'(c < 4));
      tick();
      if (acc) wc++;
    end
    chk("bp words accepted", 160'(wc), 160'd4);
    ifm.recv_rdy = 8'h80;
    pc = 0;
    for (int c = 0; c < 6; c++) begin
      msend(0, 7, 128'(wc), 1'b1);
      #1;
      acc = ifm.send_rdy[0];
      chk($sformatf("bp push+pop c%0d", c), 160'(acc), 160'd1);
      chk($sformatf("bp order c%0d", c), 160'(ifm.recv_word[7*128 +: 128]), 160'(pc));
      tick();
      if (acc) wc++;
      pc++;
    end
    msend(0, 7, 128'd0, 1'b0);
    repeat (5) tick();
    #1;
    chk("bp drained", 160'(ifm.recv_en[7]), 160'd0);
    ifm.recv_rdy = 8'h00;

    // Mid-stream reset with FIFO 2 holding three words.
    for (int k = 0; k < 3; k++) begin
      tick();
      msend(4, 2, 128'h200 + 128'(k), 1'b1);
      #1;
      chk($sformatf("fill grant %0d", k), 160'(ifm.send_rdy), 160'h10);
    end
    tick();
    msend(4, 2, 128'd0, 1'b0);
    #1;
    chk("fill head", 160'(ifm.recv_word[2*128 +: 128]), 160'h200);
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    #1;
    chk("mid-rst recv_en", 160'(ifm.recv_en), 160'd0);
    msend(1, 2, 128'h301, 1'b1);
    msend(6, 2, 128'h306, 1'b1);
    #1;
    chk("mid-rst ptr restart", 160'(ifm.send_rdy), 160'h02);
    tick();
    msend(1, 2, 128'h301, 1'b0);
    #1;
    chk("mid-rst second grant", 160'(ifm.send_rdy), 160'h40);
    tick();
    ifm.send_en = '0;
    ifm.recv_rdy = 8'h04;
    repeat (3) tick();
    ifm.recv_rdy = 8'h00;

    // N=1: destination field ignored.
    if1.send_en = 1'b1; if1.send_to = 1'b1; if1.send_word = 16'hBEEF; if1.recv_rdy = 1'b1;
    #1;
    chk("n1 send_rdy", 160'(if1.send_rdy), 160'd1);
    tick();
    if1.send_en = 1'b0;
    #1;
    chk("n1 recv_en", 160'(if1.recv_en), 160'd1);
    chk("n1 recv_word", 160'(if1.recv_word), 160'hBEEF);
    chk("n1 recv_from", 160'(if1.recv_from), 160'd0);
    tick();
    #1;
    chk("n1 drained", 160'(if1.recv_en), 160'd0);

    // N=6: out-of-range destination is never granted.
    if6.send_en = 6'b000100; if6.send_to[6 +: 3] = 3'd7; if6.send_word[2*16 +: 16] = 16'h1234;
    if6.recv_rdy = 6'h3F;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("n6 bad dst c%0d", c), 160'(if6.send_rdy), 160'd0);
      tick();
    end
    chk("n6 nothing stored", 160'(if6.recv_en), 160'd0);
    if6.send_to[6 +: 3] = 3'd5;
    #1;
    chk("n6 good dst", 160'(if6.send_rdy), 160'h04);
    tick();
    if6.send_en = '0;
    #1;
    chk("n6 recv_en", 160'(if6.recv_en), 160'h20);
    chk("n6 recv_word", 160'(if6.recv_word[5*16 +: 16]), 160'h1234);
    chk("n6 recv_from", 160'(if6.recv_from[15 +: 3]), 160'd2);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/interconn_rr.md
# interconn_rr

Buffered, flow-controlled crossbar between the N MVUs; the next generation of the combinational-select interconnect. Each sender addresses a destination per word rather than each receiver selecting a source. Senders contending for one destination are arbitrated round-robin. Each destination owns a D-deep FIFO with valid/ready back-pressure on both sides.

## Interface
- N, 8, number of MVU ports (≥1)
- W, 128, word width in bits
- D, 4, per-destination FIFO depth (power of 2, ≥2)
- A (localparam), max(1, clog2(N)), port-index width
- clk  in  1  clock; all logic on rising edge
- clr_n  in  1  reset, synchronous, active-low
- send_en  in  N  sender i presents a word
- send_to  in  N*A  destination index of sender i (field i*A +: A); ignored when N=1
- send_word  in  N*W  word of sender i (field i*W +: W)
- send_rdy  out  N  sender i's word is accepted this cycle (combinational)
- recv_en  out  N  FIFO j non-empty; head word valid
- recv_word  out  N*W  head word of FIFO j
- recv_from  out  N*A  source index of head word of FIFO j
- recv_rdy  in  N  receiver j pops the head this cycle

## Operation
- Transfer on sender i: send_en[i] & send_rdy[i] at a rising edge. Pop on receiver j: recv_en[j] & recv_rdy[j].
- Sender protocol: once send_en[i] is raised, send_to and send_word are held stable until accepted. send_rdy never depends on a combinational path from send_rdy.
- Per destination j, the request set is every i with send_en[i] and send_to[i]==j.
- Arbiter j grants at most one requester, searching from ptr[j] upward, modulo N.
- Grant is allowed only when FIFO j is not full, or it is full and a pop occurs in the same cycle.
- send_rdy[i] = 1 iff i is granted. A sender targets one destination, so it gets at most one grant.
- ptr[j] moves to (grantee+1) mod N only on a grant. With no grant it holds.
- send_to ≥ N (N not a power of 2) is never granted; send_rdy stays 0.
- FIFO j stores {source index, word}. recv_from and recv_word present the head.
- Simultaneous push and pop: occupancy is unchanged.
- Pop from an empty FIFO is ignored. recv_rdy while recv_en=0 is legal and has no effect.
- recv_word and recv_from are defined only while recv_en=1.

## Timing
- Reset (clr_n=0 at an edge): all FIFOs empty, all ptr = 0.
- After reset: recv_en=0, recv_word=0, recv_from=0.
- While clr_n=0: send_rdy=0. Words in flight and buffered are discarded, including on mid-operation reset.
- Latency: a word accepted at edge k is visible on recv_en/recv_word/recv_from right after edge k, i.e. in the next cycle.
- Full-to-empty cut-through is not provided; minimum latency is one cycle.
- Throughput: 1 word/cycle per destination. All N destinations run in parallel.
- recv_en and recv_word come from registers, with no combinational path from the send_* inputs.
- send_rdy is combinational from send_en, send_to, FIFO occupancy and recv_rdy.
- Fairness: with k persistent requesters to j and continuous pops, each is granted once every k cycles.
- Order: words from one sender to one destination arrive in send order.

## Structure
- The shared package interconn_pkg holds:
  - the clamped clog2 function for A
  - the default N/W/D constants
- Sub-module interconn_fifo: synchronous FIFO, width W+A, depth D.
  - Ports: push, pop, full, empty, head.
  - Push-when-full is allowed only with a simultaneous pop.
  - Instantiated N times.
- Arbiter and request decode stay in the top level, one generate iteration per destination.

## Test plan
- Reset: drive clr_n=0 with random send_en and recv_rdy → send_rdy=0, recv_en=0, recv_word=0 during reset and on the first cycle after.
- Point-to-point, N=8: sender 3 sends 0xA5 to 6, recv_rdy[6]=1 → recv_en[6]=1 next cycle with recv_word=0xA5, recv_from=3. All other recv_en stay 0.
- Contention: senders 0, 2, 5 all target 1 continuously with recv_rdy[1]=1 → grant order 0, 2, 5, 0, 2, 5 and one word per cycle.
- Back-pressure, D=4: sender 0 streams to 7 with recv_rdy[7]=0 → 4 accepts, then send_rdy[0]=0. Raising recv_rdy[7] lets a push and a pop occur in the same cycle, and words arrive in order.
- Mid-stream reset: FIFO 2 holding 3 words, pulse clr_n low for 1 cycle → recv_en[2]=0 afterwards and ptr restarts at 0.
- Edge configs: N=1 passes words with send_to ignored. With N=6, send_to=7 never gets send_rdy.
